dmi_core_to_jtag_resp: RTL

DMI_CORE_TO_JTAG_RESP -- requirements
Module: dmi_core_to_jtag_resp

---
 rtl/dmi_pkg.sv | 28 ++
 rtl/dmi_sync_2ff.sv | 39 +++
 rtl/dmi_core_to_jtag_resp.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// Shared definitions for the DMI response path: FSM states, status codes and data width.
package dmi_pkg;

  localparam int unsigned DMI_DATA_W = 32;

  localparam logic [1:0] DMI_OK     = 2'b00;
  localparam logic [1:0] DMI_FAILED = 2'b10;
  localparam logic [1:0] DMI_BUSY   = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWaitCore,
    StReq,
    StRelease
  } dmi_state_e;

  // An overrun reported by the host takes priority over the access outcome.
  function automatic logic [1:0] dmi_status(input logic overrun, input logic failed);
    if (overrun) begin
      return DMI_BUSY;
    end else if (failed) begin
      return DMI_FAILED;
    end else begin
      return DMI_OK;
    end
  endfunction

endpackage

// File: rtl/dmi_sync_2ff.sv
// Two-flop level synchronizer; a technology cell can be swapped in via TECH_SPECIFIC_RV_SYNC.
module dmi_sync_2ff #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  DEFAULT = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

`ifdef TECH_SPECIFIC_RV_SYNC
  tech_rv_sync #(
    .WIDTH   (WIDTH),
    .DEFAULT (DEFAULT)
  ) u_tech_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (d_i),
    .q_o    (q_o)
  );
`else
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= DEFAULT;
      sync_q <= DEFAULT;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
`endif

endmodule

// File: rtl/dmi_core_to_jtag_resp.sv
// Returns core DMI access results to the TCK domain over a four-phase req/ack handshake,
// with a response timeout and overrun reporting for accesses issued while busy.
module dmi_core_to_jtag_resp
  import dmi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  reg_en_i,
  input  logic                  reg_wr_en_i,
  input  logic                  core_resp_valid_i,
  input  logic                  core_resp_err_i,
  input  logic [DMI_DATA_W-1:0] core_rdata_i,
  input  logic                  jtag_ack_i,
  output logic                  rsp_req_o,
  output logic [DMI_DATA_W-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_status_o,
  output logic                  busy_o
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  dmi_state_e            state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  wr_q;
  logic                  overrun_q;
  logic                  rsp_req_q;
  logic [DMI_DATA_W-1:0] rsp_rdata_q;
  logic [1:0]            rsp_status_q;
  logic                  ack_s;

  logic                  enter_req;
  logic [DMI_DATA_W-1:0] req_rdata;
  logic [1:0]            req_status;

  dmi_sync_2ff #(
    .WIDTH   (1),
    .DEFAULT (1'b0)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (jtag_ack_i),
    .q_o    (ack_s)
  );

  // A core response arriving on the expiry cycle wins over the timeout.
  always_comb begin
    enter_req  = 1'b0;
    req_rdata  = '0;
    req_status = DMI_OK;
    if (state_q == StWaitCore) begin
      if (core_resp_valid_i) begin
        enter_req  = 1'b1;
        req_rdata  = wr_q ? '0 : core_rdata_i;
        req_status = dmi_status(overrun_q, core_resp_err_i);
      end else if (cnt_q == CntLast) begin
        enter_req  = 1'b1;
        req_status = dmi_status(overrun_q, 1'b1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      overrun_q    <= 1'b0;
      rsp_req_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= DMI_OK;
    end else begin
      if (state_q != StIdle && reg_en_i) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (reg_en_i) begin
            state_q <= StWaitCore;
            wr_q    <= reg_wr_en_i;
            cnt_q   <= '0;
          end
        end
        StWaitCore: begin
          if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntW'(1);
          end
          if (enter_req) begin
            state_q      <= StReq;
            rsp_req_q    <= 1'b1;
            rsp_rdata_q  <= req_rdata;
            rsp_status_q <= req_status;
            // Consumed by this response unless another access collides right now.
            overrun_q    <= reg_en_i;
          end
        end
        StReq: begin
          if (ack_s) begin
            state_q   <= StRelease;
            rsp_req_q <= 1'b0;
          end
        end
        StRelease: begin
          if (!ack_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_req_o    = rsp_req_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_status_o = rsp_status_q;
  assign busy_o       = (state_q != StIdle);

endmodule
